mau_host_driver: RTL

- Host-side initiator for the matrix algebra unit: the other end of its host_instruction/data_in/data_out/busy_flag interface.
- Accepts one command at a time (LOAD, EXEC, READ) over a valid/ready handshake.
- Buffers a full matrix so the non-stallable MAU byte stream is always issued or captured back-to-back.
- Sits between the system bus adapter and the MAU top level.

---
 rtl/mau_host_pkg.sv | 29 ++
 rtl/mau_byte_buffer.sv | 24 ++
 rtl/mau_host_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mau_host_pkg.sv
// Shared definitions for the MAU host driver: command codes, FSM encoding and sizing helpers.
package mau_host_pkg;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_EXEC = 2'd1;
  localparam logic [1:0] CMD_READ = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StFill,
    StIssue,
    StStream,
    StWaitHi,
    StWaitLo,
    StLatency,
    StCapture,
    StDrain
  } state_e;

  function automatic int unsigned num_bytes(input int unsigned dim);
    return dim * dim;
  endfunction

  // One spare bit so a count can reach the full element count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mau_byte_buffer.sv
// Single-matrix byte store: one synchronous write port, one asynchronous read port.
module mau_byte_buffer #(
  parameter int unsigned NumBytes = 64,
  parameter int unsigned AddrW    = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [NumBytes];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mau_host_driver.sv
// Host-side initiator for the MAU: buffers a whole matrix so the MAU byte stream
// is always issued or captured back-to-back, and serialises LOAD/EXEC/READ commands.
module mau_host_driver
  import mau_host_pkg::*;
#(
  parameter int unsigned MatrixDim   = 8,
  parameter logic [7:0]  NopInstr    = 8'h00,
  parameter int unsigned ReadLat     = 2,
  parameter int unsigned BusyTimeout = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_instr,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       done,
  output logic       error,
  output logic [7:0] mau_instr,
  output logic [7:0] mau_data_in,
  input  logic [7:0] mau_data_out,
  input  logic       mau_busy
);

  localparam int unsigned NumBytes = num_bytes(MatrixDim);
  localparam int unsigned AddrW    = $clog2(NumBytes);
  localparam int unsigned CntW     = cnt_width(NumBytes);
  localparam int unsigned TmoW     = cnt_width(BusyTimeout);

  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);
  localparam logic [CntW-1:0] LatLast = CntW'((ReadLat > 1) ? ReadLat - 2 : 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(BusyTimeout - 1);

  state_e          state_q;
  logic [1:0]      type_q;
  logic [7:0]      instr_q;
  logic [CntW-1:0] cnt_q;
  logic [TmoW-1:0] tmo_q;
  logic            cmd_ready_q;
  logic            wr_ready_q;
  logic            rd_valid_q;
  logic [7:0]      rd_data_q;
  logic            done_q;
  logic            error_q;
  logic [7:0]      mau_instr_q;
  logic [7:0]      mau_data_in_q;

  logic             buf_we;
  logic [AddrW-1:0] buf_waddr;
  logic [7:0]       buf_wdata;
  logic [AddrW-1:0] buf_raddr;
  logic [7:0]       buf_rdata;
  logic             drain_last_hs;

  mau_byte_buffer #(
    .NumBytes (NumBytes),
    .AddrW    (AddrW)
  ) u_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  // Read port looks one byte ahead so the registered outputs carry buffer[cnt] next cycle.
  always_comb begin
    buf_raddr = '0;
    buf_we    = 1'b0;
    buf_waddr = cnt_q[AddrW-1:0];
    buf_wdata = wr_data;
    if (state_q == StStream || state_q == StDrain) begin
      buf_raddr = cnt_q[AddrW-1:0] + AddrW'(1);
    end
    if (state_q == StFill) begin
      buf_we = wr_valid && wr_ready_q;
    end else if (state_q == StCapture) begin
      buf_we    = 1'b1;
      buf_wdata = mau_data_out;
    end
  end

  assign drain_last_hs = (state_q == StDrain) && (cnt_q == LastCnt) && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      type_q        <= CMD_LOAD;
      instr_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      cmd_ready_q   <= 1'b1;
      wr_ready_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mau_instr_q   <= NopInstr;
      mau_data_in_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            type_q      <= cmd_type;
            instr_q     <= cmd_instr;
            cnt_q       <= '0;
            tmo_q       <= '0;
            unique case (cmd_type)
              CMD_LOAD: begin
                state_q    <= StFill;
                wr_ready_q <= 1'b1;
              end
              CMD_EXEC, CMD_READ: begin
                state_q     <= StIssue;
                mau_instr_q <= cmd_instr;
              end
              default: begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        StFill: begin
          if (wr_valid) begin
            if (cnt_q == LastCnt) begin
              state_q     <= StIssue;
              wr_ready_q  <= 1'b0;
              cnt_q       <= '0;
              mau_instr_q <= instr_q;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StIssue: begin
          mau_instr_q <= NopInstr;
          cnt_q       <= '0;
          tmo_q       <= '0;
          unique case (type_q)
            CMD_LOAD: begin
              state_q       <= StStream;
              mau_data_in_q <= buf_rdata;
            end
            CMD_EXEC: state_q <= StWaitHi;
            default:  state_q <= (ReadLat > 1) ? StLatency : StCapture;
          endcase
        end
        StStream: begin
          if (cnt_q == LastCnt) begin
            state_q       <= StWaitLo;
            mau_data_in_q <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
          end else begin
            cnt_q         <= cnt_q + CntW'(1);
            mau_data_in_q <= buf_rdata;
          end
        end
        StWaitHi: begin
          if (mau_busy) begin
            state_q <= StWaitLo;
            tmo_q   <= '0;
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
            error_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StWaitLo: begin
          if (!mau_busy) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
            error_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StLatency: begin
          if (cnt_q == LatLast) begin
            state_q <= StCapture;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StCapture: begin
          if (cnt_q == LastCnt) begin
            state_q    <= StDrain;
            cnt_q      <= '0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= buf_rdata;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          if (rd_ready) begin
            if (cnt_q == LastCnt) begin
              // done is raised combinationally on this handshake, so ready returns at once.
              state_q     <= StIdle;
              rd_valid_q  <= 1'b0;
              rd_data_q   <= '0;
              cmd_ready_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + CntW'(1);
              rd_data_q <= buf_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q && (state_q == StIdle) && !rst;
  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q || drain_last_hs;
  assign error       = error_q;
  assign mau_instr   = mau_instr_q;
  assign mau_data_in = mau_data_in_q;

endmodule
